// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM nibble link (framer and deframer sides).
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 4;

  // LSB position of channel k inside a packed frame word
  function automatic int ch_lsb(input int k, input int ch_w);
    return k * ch_w;
  endfunction

endpackage

// File: rtl/tdm_shadow_buf.sv
// Frame assembly register file with indexed write and atomic commit to the output word.
module tdm_shadow_buf
  import tdm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [CH_W-1:0]          i_wr_data,
  input  logic                     i_commit,
  output logic [NUM_CH*CH_W-1:0]   o_ch_out
);

  logic [CH_W-1:0] r_shadow [NUM_CH];
  logic [CH_W-1:0] r_out    [NUM_CH];

  // Commit samples the shadow before any same-edge write, so the next
  // frame's channel 0 can land while the previous frame is published.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
        r_out[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_wr_en && (i_wr_idx == IDX_W'(k))) r_shadow[k] <= i_wr_data;
        if (i_commit) r_out[k] <= r_shadow[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_out
      assign o_ch_out[ch_lsb(gi, CH_W) +: CH_W] = r_out[gi];
    end
  endgenerate

endmodule

// File: rtl/tdm_deframer.sv
// Frame-synchronised TDM receiver: hunts for SOF, assembles a frame, commits it atomically.
module tdm_deframer
  import tdm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int ERR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CH_W-1:0]        rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_sof,
  output logic [NUM_CH*CH_W-1:0] ch_out,
  output logic                   frame_done,
  output logic                   locked,
  output logic                   frame_err,
  output logic [ERR_W-1:0]       err_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  tdm_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_commit;
  logic             r_frame_done;
  logic             r_frame_err;
  logic [ERR_W-1:0] r_err_count;

  logic             w_beat;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_beat   = enable & rx_valid;
  // In HUNT only an SOF is stored; in RECV everything but a missing-SOF beat is stored
  assign w_wr_en  = w_beat & (rx_sof | ((r_state == RECV) & (r_idx != '0)));
  assign w_wr_idx = rx_sof ? '0 : r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= HUNT;
      r_idx        <= '0;
      r_commit     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_commit     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_done <= r_commit;
      if (!enable) begin
        if (r_state == RECV && r_idx != '0) begin
          r_state <= HUNT;
          r_idx   <= '0;
        end
      end else if (rx_valid) begin
        case (r_state)
          HUNT: begin
            if (rx_sof) begin
              r_state <= RECV;
              r_idx   <= IDX_W'(1);
            end
          end
          RECV: begin
            if (rx_sof) begin
              r_idx <= IDX_W'(1);
              if (r_idx != '0) begin
                r_frame_err <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              end
            end else if (r_idx == '0) begin
              r_frame_err <= 1'b1;
              if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
              r_state <= HUNT;
            end else if (r_idx == LAST_IDX) begin
              r_idx    <= '0;
              r_commit <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  tdm_shadow_buf #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk       (clk),
    .i_reset   (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (rx_data),
    .i_commit  (r_commit),
    .o_ch_out  (ch_out)
  );

  assign frame_done = r_frame_done;
  assign locked     = (r_state == RECV);
  assign frame_err  = r_frame_err;
  assign err_count  = r_err_count;

endmodule
